jbi_ncio_mrqq_fifo: RTL

JBI_NCIO_MRQQ_FIFO -- requirements
Module: jbi_ncio_mrqq_fifo

---
 rtl/jbi_ncio_mrqq_fifo_if.sv | 29 ++
 rtl/jbi_ncio_mrqq_fifo.sv | 112 +++++++++++
 2 files changed

// File: rtl/jbi_ncio_mrqq_fifo_if.sv
// Handshake bundle for the JBI NCIO MRQQ FIFO: write port, read port and status.
// master = producer/consumer side, slave = FIFO side.
interface jbi_ncio_mrqq_fifo_if #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 16
);
    logic                       hold;
    logic                       wr_vld;
    logic [WIDTH-1:0]           wr_data;
    logic                       wr_par_inj;
    logic                       wr_rdy;
    logic                       rd_vld;
    logic [WIDTH-1:0]           rd_data;
    logic                       rd_ack;
    logic                       rd_par_err;
    logic [$clog2(DEPTH):0]     count;
    logic                       hwm;
    logic                       proto_err;

    modport master (
        output hold, wr_vld, wr_data, wr_par_inj, rd_ack,
        input  wr_rdy, rd_vld, rd_data, rd_par_err, count, hwm, proto_err
    );

    modport slave (
        input  hold, wr_vld, wr_data, wr_par_inj, rd_ack,
        output wr_rdy, rd_vld, rd_data, rd_par_err, count, hwm, proto_err
    );
endinterface

// File: rtl/jbi_ncio_mrqq_fifo.sv
// DEPTH-entry FIFO with a registered head stage, high-water flag and sticky protocol error.
// Define JBI_MRQQ_PAR_EN to store and check one even-parity bit per entry.
module jbi_ncio_mrqq_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned HWM   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    jbi_ncio_mrqq_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef JBI_MRQQ_PAR_EN
    localparam int unsigned EW = WIDTH + 1;
`else
    localparam int unsigned EW = WIDTH;
`endif

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_par_err_q, rd_par_err_d;
    logic             hwm_q, hwm_d;
    logic             proto_err_q, proto_err_d;

    logic             full;
    logic             accept;
    logic             pop;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head_entry;
    logic [CW-1:0]    held_after_pop;

    assign full        = (count_q == CW'(DEPTH));
    assign bus.wr_rdy  = !rst && !bus.hold && !full;
    assign accept      = bus.wr_vld && bus.wr_rdy;
    assign pop         = bus.rd_ack && rd_vld_q && !bus.hold;

`ifdef JBI_MRQQ_PAR_EN
    assign wr_entry = {(^bus.wr_data) ^ bus.wr_par_inj, bus.wr_data};
`else
    logic unused_par_inj;
    assign unused_par_inj = bus.wr_par_inj;
    assign wr_entry       = bus.wr_data;
`endif

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CW'(1);
        end
        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

        // Only entries already in storage before this edge may be loaded into the
        // head stage; a write landing this edge shows up one edge later.
        held_after_pop = count_q - CW'(pop);
        head_entry     = mem_q[rd_ptr_d];
        rd_vld_d       = (held_after_pop != '0);
        rd_data_d      = rd_vld_d ? head_entry[WIDTH-1:0] : rd_data_q;
`ifdef JBI_MRQQ_PAR_EN
        rd_par_err_d   = rd_vld_d && (head_entry[WIDTH] != (^head_entry[WIDTH-1:0]));
`else
        rd_par_err_d   = 1'b0;
`endif
        hwm_d          = (count_d >= CW'(HWM));
        proto_err_d    = proto_err_q || (bus.rd_ack && !rd_vld_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_vld_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_par_err_q <= 1'b0;
            hwm_q        <= 1'b0;
            proto_err_q  <= 1'b0;
        end else if (!bus.hold) begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_vld_q     <= rd_vld_d;
            rd_data_q    <= rd_data_d;
            rd_par_err_q <= rd_par_err_d;
            hwm_q        <= hwm_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Storage is never cleared; accept already excludes reset and hold.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign bus.rd_vld     = rd_vld_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_par_err = rd_par_err_q;
    assign bus.count      = count_q;
    assign bus.hwm        = hwm_q;
    assign bus.proto_err  = proto_err_q;
endmodule
